// File: rtl/sram_bank_arbiter_pkg.sv
// Shared constants and types for the SRAM bank arbiter: array geometry,
// requester IDs and the read-return tag carried down each bank's pipeline.
package sram_bank_arbiter_pkg;

   localparam int NUM_SRAMS      = 8;
   localparam int MAX_ADDR_WIDTH = 10;
   localparam int INT8_SIZE      = 8;
   localparam int SRAM_WIDTH_O   = 32;
   localparam int NUM_REQ        = 6;
   localparam int SRAM_RD_LAT    = 1;
   localparam int REQ_ID_W       = $clog2(NUM_REQ);

   typedef enum logic [REQ_ID_W-1:0] {
      REQ_GEMM1  = 3'd0,
      REQ_GEMM2  = 3'd1,
      REQ_ELEM0  = 3'd2,
      REQ_ELEM1  = 3'd3,
      REQ_AXI_WR = 3'd4,
      REQ_AXI_RD = 3'd5
   } req_id_e;

   typedef struct packed {
      logic    valid;
      req_id_e id;
   } rd_tag_t;

endpackage

// File: rtl/sram_bank_arbiter_rr.sv
// Round-robin arbiter for one bank: the first request at or after the
// pointer wins, and the pointer moves to just past the winner.
module rr_arbiter #(
   parameter int N = 6
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] req,
   output logic [N-1:0] gnt
);

   localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

   logic [PTR_W-1:0] ptr;
   logic [PTR_W-1:0] win;
   logic             found;

   // NOTE: every output of a combinational block gets a default before any
   // conditional assignment, otherwise synthesis infers a latch.
   always_comb begin
      gnt   = '0;
      win   = '0;
      found = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (!found && req[(int'(ptr) + i) % N]) begin
            found                     = 1'b1;
            gnt[(int'(ptr) + i) % N]  = 1'b1;
            win                       = PTR_W'((int'(ptr) + i) % N);
         end
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop
   // samples pre-edge values regardless of process ordering.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr <= '0;
      end else if (found) begin
         ptr <= (int'(win) == N - 1) ? '0 : win + 1'b1;
      end
   end

endmodule

// File: rtl/sram_bank_arbiter.sv
// Per-bank round-robin arbitration of NUM_REQ requesters onto a multi-bank
// SRAM, with registered bank commands and tagged read return.
// Optional per-requester stall counters: define SRAM_ARB_PERF_CNT_EN.
module sram_bank_arbiter #(
   parameter int NUM_REQ   = sram_bank_arbiter_pkg::NUM_REQ,
   parameter int NUM_BANKS = sram_bank_arbiter_pkg::NUM_SRAMS,
   parameter int IDX_W     = $clog2(NUM_BANKS),
   parameter int ADDR_W    = sram_bank_arbiter_pkg::MAX_ADDR_WIDTH,
   parameter int WDATA_W   = sram_bank_arbiter_pkg::INT8_SIZE,
   parameter int RDATA_W   = sram_bank_arbiter_pkg::SRAM_WIDTH_O,
   parameter int RD_LAT    = sram_bank_arbiter_pkg::SRAM_RD_LAT
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [NUM_REQ-1:0]             req_valid,
   input  logic [NUM_REQ-1:0]             req_we,
   input  logic [NUM_REQ*IDX_W-1:0]       req_idx,
   input  logic [NUM_REQ*ADDR_W-1:0]      req_addr,
   input  logic [NUM_REQ*WDATA_W-1:0]     req_wdata,
   output logic [NUM_REQ-1:0]             req_gnt,
   output logic [NUM_REQ-1:0]             rsp_valid,
   output logic [NUM_REQ*RDATA_W-1:0]     rsp_data,
   output logic [NUM_BANKS-1:0]           sram_en,
   output logic [NUM_BANKS-1:0]           sram_we,
   output logic [NUM_BANKS*ADDR_W-1:0]    sram_addr,
   output logic [NUM_BANKS*WDATA_W-1:0]   sram_wdata,
   input  logic [NUM_BANKS*RDATA_W-1:0]   sram_rdata,
   output logic                           bad_idx_err
`ifdef SRAM_ARB_PERF_CNT_EN
   ,
   output logic [NUM_REQ*32-1:0]          stall_cnt
`endif
);

   import sram_bank_arbiter_pkg::*;

   logic [NUM_REQ-1:0] bank_req [NUM_BANKS];
   logic [NUM_REQ-1:0] bank_gnt [NUM_BANKS];
   logic               nxt_we    [NUM_BANKS];
   logic [ADDR_W-1:0]  nxt_addr  [NUM_BANKS];
   logic [WDATA_W-1:0] nxt_wdata [NUM_BANKS];
   req_id_e            nxt_id    [NUM_BANKS];
   req_id_e            cmd_id    [NUM_BANKS];
   rd_tag_t            pipe      [NUM_BANKS][RD_LAT];
   logic               any_bad;

   // Out-of-range bank indices match no bank, so they are simply never granted.
   always_comb begin
      any_bad = 1'b0;
      for (int b = 0; b < NUM_BANKS; b++) begin
         for (int r = 0; r < NUM_REQ; r++) begin
            bank_req[b][r] = req_valid[r] && (int'(req_idx[r*IDX_W +: IDX_W]) == b);
         end
      end
      for (int r = 0; r < NUM_REQ; r++) begin
         if (req_valid[r] && int'(req_idx[r*IDX_W +: IDX_W]) >= NUM_BANKS) any_bad = 1'b1;
      end
   end

   for (genvar gb = 0; gb < NUM_BANKS; gb++) begin : g_bank
      rr_arbiter #(.N(NUM_REQ)) u_arb (
         .clk (clk),
         .rst (rst),
         .req (bank_req[gb]),
         .gnt (bank_gnt[gb])
      );
   end

   always_comb begin
      req_gnt = '0;
      for (int b = 0; b < NUM_BANKS; b++) begin
         req_gnt   = req_gnt | bank_gnt[b];
         nxt_we[b]    = 1'b0;
         nxt_addr[b]  = '0;
         nxt_wdata[b] = '0;
         nxt_id[b]    = REQ_GEMM1;
         for (int r = 0; r < NUM_REQ; r++) begin
            if (bank_gnt[b][r]) begin
               nxt_we[b]    = req_we[r];
               nxt_addr[b]  = req_addr[r*ADDR_W +: ADDR_W];
               nxt_wdata[b] = req_wdata[r*WDATA_W +: WDATA_W];
               nxt_id[b]    = req_id_e'(r);
            end
         end
      end
   end

   // NOTE: the return pipelines are reset (not just their valid bits) so a
   // read in flight at reset can never surface as a response afterwards.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sram_en     <= '0;
         sram_we     <= '0;
         sram_addr   <= '0;
         sram_wdata  <= '0;
         bad_idx_err <= 1'b0;
         for (int b = 0; b < NUM_BANKS; b++) begin
            cmd_id[b] <= REQ_GEMM1;
            for (int s = 0; s < RD_LAT; s++) pipe[b][s] <= '0;
         end
      end else begin
         if (any_bad) bad_idx_err <= 1'b1;
         for (int b = 0; b < NUM_BANKS; b++) begin
            sram_en[b]                          <= |bank_gnt[b];
            sram_we[b]                          <= nxt_we[b];
            sram_addr[b*ADDR_W +: ADDR_W]       <= nxt_addr[b];
            sram_wdata[b*WDATA_W +: WDATA_W]    <= nxt_wdata[b];
            cmd_id[b]                           <= nxt_id[b];
            pipe[b][0] <= '{valid: sram_en[b] & ~sram_we[b], id: cmd_id[b]};
            for (int s = 1; s < RD_LAT; s++) pipe[b][s] <= pipe[b][s-1];
         end
      end
   end

   // Each pipeline head routes its bank's read data back to the issuing requester.
   always_comb begin
      rsp_valid = '0;
      rsp_data  = '0;
      for (int b = 0; b < NUM_BANKS; b++) begin
         for (int r = 0; r < NUM_REQ; r++) begin
            if (pipe[b][RD_LAT-1].valid && pipe[b][RD_LAT-1].id == req_id_e'(r)) begin
               rsp_valid[r]                     = 1'b1;
               rsp_data[r*RDATA_W +: RDATA_W]   = sram_rdata[b*RDATA_W +: RDATA_W];
            end
         end
      end
   end

`ifdef SRAM_ARB_PERF_CNT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt <= '0;
      end else begin
         for (int r = 0; r < NUM_REQ; r++) begin
            if (req_valid[r] && !req_gnt[r] && stall_cnt[r*32 +: 32] != 32'hFFFF_FFFF)
               stall_cnt[r*32 +: 32] <= stall_cnt[r*32 +: 32] + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_sram_bank_arbiter.sv
// Directed bench for sram_bank_arbiter with a behavioural SRAM and a
// per-requester response scoreboard checked by an independent monitor.
module tb_sram_bank_arbiter;

   localparam int NR    = 6;
   localparam int NB    = 8;
   localparam int IW    = 4;
   localparam int AW    = 10;
   localparam int WW    = 8;
   localparam int RW    = 32;
   localparam int DEPTH = 1 << AW;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [NR-1:0]    req_valid, req_we, req_gnt, rsp_valid;
   logic [NR*IW-1:0] req_idx;
   logic [NR*AW-1:0] req_addr;
   logic [NR*WW-1:0] req_wdata;
   logic [NR*RW-1:0] rsp_data;
   logic [NB-1:0]    sram_en, sram_we;
   logic [NB*AW-1:0] sram_addr;
   logic [NB*WW-1:0] sram_wdata;
   logic [NB*RW-1:0] sram_rdata;
   logic             bad_idx_err;
`ifdef SRAM_ARB_PERF_CNT_EN
   logic [NR*32-1:0] stall_cnt;
`endif

   sram_bank_arbiter #(
      .NUM_REQ(NR), .NUM_BANKS(NB), .IDX_W(IW), .ADDR_W(AW),
      .WDATA_W(WW), .RDATA_W(RW), .RD_LAT(1)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid   (req_valid),
      .req_we      (req_we),
      .req_idx     (req_idx),
      .req_addr    (req_addr),
      .req_wdata   (req_wdata),
      .req_gnt     (req_gnt),
      .rsp_valid   (rsp_valid),
      .rsp_data    (rsp_data),
      .sram_en     (sram_en),
      .sram_we     (sram_we),
      .sram_addr   (sram_addr),
      .sram_wdata  (sram_wdata),
      .sram_rdata  (sram_rdata),
      .bad_idx_err (bad_idx_err)
`ifdef SRAM_ARB_PERF_CNT_EN
      ,
      .stall_cnt   (stall_cnt)
`endif
   );

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   typedef struct {
      logic [RW-1:0] data;
      int            cyc;
   } exp_t;

   exp_t          exp_q [NR][$];
   logic [RW-1:0] ref_wr [int];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Initial memory contents; bank 2 addr 0x10 holds 0x5A.
   function automatic logic [RW-1:0] pat(input int b, input int a);
      if (b == 2 && a == 'h10) return 32'h5A;
      return 32'hA500_0000 | RW'(b << 12) | RW'(a);
   endfunction

   function automatic logic [RW-1:0] ref_rd(input int b, input int a);
      if (ref_wr.exists(b * DEPTH + a)) return ref_wr[b * DEPTH + a];
      return pat(b, a);
   endfunction

   // Behavioural SRAM, one registered read port per bank.
   logic [RW-1:0] mem     [NB][DEPTH];
   bit            written [NB][DEPTH];
   logic [RW-1:0] rdata_q [NB];

   always @(posedge clk) begin
      for (int b = 0; b < NB; b++) begin
         if (sram_en[b]) begin
            if (sram_we[b]) begin
               mem[b][sram_addr[b*AW +: AW]]     <= RW'(sram_wdata[b*WW +: WW]);
               written[b][sram_addr[b*AW +: AW]] <= 1'b1;
            end else begin
               rdata_q[b] <= written[b][sram_addr[b*AW +: AW]] ? mem[b][sram_addr[b*AW +: AW]]
                                                               : pat(b, int'(sram_addr[b*AW +: AW]));
            end
         end
      end
   end

   always_comb begin
      for (int b = 0; b < NB; b++) sram_rdata[b*RW +: RW] = rdata_q[b];
   end

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: every presented response must match the head of its requester's queue.
   always @(negedge clk) begin
      logic [NR*RW-1:0] mask;
      exp_t             e;
      mask = '0;
      for (int r = 0; r < NR; r++) begin
         if (rsp_valid[r]) begin
            mask[r*RW +: RW] = '1;
            if (exp_q[r].size() == 0) begin
               check($sformatf("rsp_unexpected_req%0d", r), 64'(rsp_valid[r]), 64'd0);
            end else begin
               e = exp_q[r].pop_front();
               check($sformatf("rsp_data_req%0d", r), 64'(rsp_data[r*RW +: RW]), 64'(e.data));
               check($sformatf("rsp_cycle_req%0d", r), 64'(cyc), 64'(e.cyc));
            end
         end
      end
      check("rsp_idle_zero", 64'(|(rsp_data & ~mask)), 64'd0);
   end

   task automatic set_req(input int r, input logic we, input int idx, input int addr, input int wdata);
      req_valid[r]              = 1'b1;
      req_we[r]                 = we;
      req_idx[r*IW +: IW]       = IW'(idx);
      req_addr[r*AW +: AW]      = AW'(addr);
      req_wdata[r*WW +: WW]     = WW'(wdata);
   endtask

   task automatic clr_req(input int r);
      req_valid[r] = 1'b0;
   endtask

   // One arbitration cycle: check the grant vector, record the expected
   // effect of each expected grant, and advance to just after the next edge.
   task automatic cycle(input logic [NR-1:0] exp_gnt, input bit push_rsp, input string name);
      int b, a;
      exp_t e;
      @(negedge clk);
      check(name, 64'(req_gnt), 64'(exp_gnt));
      for (int r = 0; r < NR; r++) begin
         if (exp_gnt[r]) begin
            b = int'(req_idx[r*IW +: IW]);
            a = int'(req_addr[r*AW +: AW]);
            if (req_we[r]) begin
               ref_wr[b * DEPTH + a] = RW'(req_wdata[r*WW +: WW]);
            end else if (push_rsp) begin
               e.data = ref_rd(b, a);
               e.cyc  = cyc + 2;
               exp_q[r].push_back(e);
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      req_valid = '0;
      req_we    = '0;
      req_idx   = '0;
      req_addr  = '0;
      req_wdata = '0;
      rst       = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("reset_sram_en", 64'(sram_en), 64'd0);
      check("reset_sram_we", 64'(sram_we), 64'd0);
      check("reset_sram_addr_any", 64'(|sram_addr), 64'd0);
      check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
      check("reset_bad_idx_err", 64'(bad_idx_err), 64'd0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Single read: GEMM1 reads bank 2 addr 0x10.
      set_req(0, 1'b0, 2, 'h10, 0);
      cycle(6'b000001, 1'b1, "single_gnt");
      clr_req(0);
      check("single_sram_en", 64'(sram_en), 64'h04);
      check("single_sram_we", 64'(sram_we), 64'h00);
      check("single_sram_addr", 64'(sram_addr[2*AW +: AW]), 64'h10);
      cycle(6'b000000, 1'b1, "single_idle");

      // All six requesters contend for bank 3, pointer at 0.
      for (int r = 0; r < NR; r++) set_req(r, 1'b0, 3, 'h20 + r, 0);
      for (int k = 0; k < NR; k++) begin
         cycle(NR'(1 << k), 1'b1, $sformatf("conflict_gnt_%0d", k));
         clr_req(k);
      end
      repeat (2) cycle(6'b000000, 1'b1, "conflict_idle");

      // Three banks in parallel, then read back the written words.
      set_req(0, 1'b1, 0, 5, 'h11);
      set_req(1, 1'b0, 1, 7, 0);
      set_req(4, 1'b1, 7, 9, 'h22);
      cycle(6'b010011, 1'b1, "parallel_gnt");
      clr_req(1);
      check("parallel_sram_en", 64'(sram_en), 64'h83);
      check("parallel_sram_we", 64'(sram_we), 64'h81);
      check("parallel_wdata_b0", 64'(sram_wdata[0 +: WW]), 64'h11);
      check("parallel_wdata_b7", 64'(sram_wdata[7*WW +: WW]), 64'h22);
      set_req(0, 1'b0, 0, 5, 0);
      set_req(4, 1'b0, 7, 9, 0);
      cycle(6'b010001, 1'b1, "readback_gnt");
      clr_req(0);
      clr_req(4);
      repeat (2) cycle(6'b000000, 1'b1, "parallel_idle");

      // Fairness: ELEM0 holds bank 4; AXI_RD joins and wins next.
      set_req(2, 1'b0, 4, 'h30, 0);
      cycle(6'b000100, 1'b1, "fair_elem0_first");
      set_req(5, 1'b0, 4, 'h31, 0);
      cycle(6'b100000, 1'b1, "fair_axi_rd_gnt");
      clr_req(5);
      cycle(6'b000100, 1'b1, "fair_elem0_resume");
      clr_req(2);
      repeat (2) cycle(6'b000000, 1'b1, "fair_idle");

      // Reset while a read is in flight: no response may follow.
      set_req(1, 1'b0, 5, 1, 0);
      cycle(6'b000010, 1'b0, "rst_read_gnt");
      clr_req(1);
      rst = 1'b1;
      #1;
      check("rst_mid_sram_en", 64'(sram_en), 64'd0);
      check("rst_mid_rsp_valid", 64'(rsp_valid), 64'd0);
      @(posedge clk);
      #1;
      check("rst_hold_rsp_valid", 64'(rsp_valid), 64'd0);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("rst_after_rsp_valid", 64'(rsp_valid), 64'd0);
      check("rst_after_sram_en", 64'(sram_en), 64'd0);
      // Bank 4 pointer was 3; after reset requester 0 beats requester 5.
      set_req(0, 1'b0, 4, 2, 0);
      set_req(5, 1'b0, 4, 3, 0);
      cycle(6'b000001, 1'b1, "rst_ptr_gnt");
      clr_req(0);
      cycle(6'b100000, 1'b1, "rst_ptr_next");
      clr_req(5);
`ifdef SRAM_ARB_PERF_CNT_EN
      check("stall_cnt_req5", 64'(stall_cnt[5*32 +: 32]), 64'd1);
`endif

      // Bad index: never granted, error flag sticks.
      check("bad_idx_before", 64'(bad_idx_err), 64'd0);
      set_req(3, 1'b0, 9, 4, 0);
      for (int i = 0; i < 4; i++) begin
         cycle(6'b000000, 1'b1, "bad_idx_gnt");
         check("bad_idx_err_set", 64'(bad_idx_err), 64'd1);
`ifdef SRAM_ARB_PERF_CNT_EN
         check("stall_cnt_req3", 64'(stall_cnt[3*32 +: 32]), 64'(i + 1));
`endif
      end
      clr_req(3);
      repeat (3) cycle(6'b000000, 1'b1, "drain_gnt");
      check("bad_idx_err_sticky", 64'(bad_idx_err), 64'd1);
      check("bad_idx_sram_en", 64'(sram_en), 64'd0);

      for (int r = 0; r < NR; r++)
         check($sformatf("queue_empty_req%0d", r), 64'(exp_q[r].size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
